popcount_unit: RTL and testbench

Self-contained, parametrised population-count engine: control FSM and datapath in one block. On a `start` pulse it captures a WIDTH-bit operand and counts either its ones or its zeros using one `a & (a-1)` step per cycle, so latency scales with the number of set bits. The result is held in DONE until the consumer acknowledges with `ack`. The block sits between an operand producer and a result consumer and supports back-to-back operations and abort.

---
 rtl/popcount_unit_if.sv | 30 +++
 rtl/popcount_unit.sv | 83 ++++++++
 tb/tb_popcount_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/popcount_unit_if.sv
// Operand/result handshake bundle for popcount_unit.
// The master is the producer/consumer side and the slave is the counting engine.
interface popcount_unit_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Request side: start/mode/din are taken together, and only when start is accepted.
    // Response side: done holds the result until ack; abort cancels in any state.
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic             ack;
    logic             abort;
    logic [1:0]       state;
    logic             busy;
    logic             done;
    logic             zero;
    logic [CNT_W-1:0] count;

    modport master (
        output start, mode, din, ack, abort,
        input  state, busy, done, zero, count
    );

    modport slave (
        input  start, mode, din, ack, abort,
        output state, busy, done, zero, count
    );
endinterface

// File: rtl/popcount_unit.sv
// Population-count engine: clears one set bit of the working operand per cycle.
// The result is held in DONE until acknowledged.
module popcount_unit #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    popcount_unit_if.slave        bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10,
        BAD   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
            a_d     = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_d     = bus.mode ? ~bus.din : bus.din;
                        cnt_d   = '0;
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (a_q == '0) begin
                        state_d = DONE;
                    end else begin
                        // Clears the lowest set bit; count cannot exceed WIDTH.
                        a_d   = a_q & (a_q - WIDTH'(1));
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        if (bus.start) begin
                            a_d     = bus.mode ? ~bus.din : bus.din;
                            cnt_d   = '0;
                            state_d = COUNT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Every output decodes registered state only.
    assign bus.state = state_q;
    assign bus.busy  = (state_q == COUNT);
    assign bus.done  = (state_q == DONE);
    assign bus.zero  = (state_q == DONE) && (cnt_q == '0);
    assign bus.count = cnt_q;
endmodule

// File: tb/tb_popcount_unit.sv
// Bench for popcount_unit: directed cases pinned to literal values, then random
// operations compared each cycle against a phase-level reference model.
module tb_popcount_unit;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  popcount_unit_if #(.WIDTH(WIDTH)) bus();

  popcount_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 counting, 2 holding the result.
  // While counting, progress rises by one per cycle until it reaches the popcount.
  int m_phase = 0;
  int m_target = 0;
  int m_prog = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0;
      m_prog  <= 0;
    end else if (bus.abort) begin
      m_phase <= 0;
      m_prog  <= 0;
    end else if (m_phase == 0 || (m_phase == 2 && bus.ack)) begin
      if (bus.start) begin
        m_phase  <= 1;
        m_target <= $countones(bus.mode ? ~bus.din : bus.din);
        m_prog   <= 0;
      end else if (m_phase == 2) begin
        m_phase <= 0;
      end
    end else if (m_phase == 1) begin
      if (m_prog == m_target) m_phase <= 2;
      else m_prog <= m_prog + 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_state", 32'(bus.state), m_phase);
    check("cyc_busy", 32'(bus.busy), (m_phase == 1) ? 1 : 0);
    check("cyc_done", 32'(bus.done), (m_phase == 2) ? 1 : 0);
    check("cyc_zero", 32'(bus.zero), (m_phase == 2 && m_prog == 0) ? 1 : 0);
    check("cyc_count", 32'(bus.count), m_prog);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // edges counts the accept edge as the first; busy_cyc counts busy samples.
  task automatic wait_done(input int stray_at, output int edges, output int busy_cyc);
    busy_cyc = bus.busy ? 1 : 0;
    edges = 1;
    while (!bus.done && edges < 64) begin
      if (edges == stray_at) begin
        bus.start = 1'b1;
        bus.din   = 16'hFFFF;
        bus.mode  = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      step();
      edges++;
      if (bus.busy) busy_cyc++;
    end
    bus.start = 1'b0;
    check("done_reached", 32'(bus.done), 1);
  endtask

  task automatic run_op(input logic [15:0] d, input logic m, input logic with_ack,
                        input int stray_at, output int edges, output int busy_cyc);
    bus.din   = d;
    bus.mode  = m;
    bus.start = 1'b1;
    bus.ack   = with_ack;
    step();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    wait_done(stray_at, edges, busy_cyc);
  endtask

  task automatic release_result();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    int e;
    int b;
    int seen;
    int k;
    logic [15:0] d;
    logic m;
    logic b2b;

    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.din   = '0;
    bus.ack   = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_zero", 32'(bus.zero), 0);
    check("rst_count", 32'(bus.count), 0);
    rst = 1'b1;
    step();

    run_op(16'h00F0, 1'b0, 1'b0, -1, e, b);
    check("ones_edges", e, 6);
    check("ones_busy", b, 5);
    check("ones_count", 32'(bus.count), 4);
    check("ones_zero", 32'(bus.zero), 0);

    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_done", 32'(bus.done), 1);
      check("hold_count", 32'(bus.count), 4);
    end

    bus.din   = 16'h0003;
    bus.mode  = 1'b0;
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    step();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check("b2b_state", 32'(bus.state), 1);
    check("b2b_done", 32'(bus.done), 0);
    wait_done(-1, e, b);
    check("b2b_count", 32'(bus.count), 2);
    release_result();
    check("ack_idle", 32'(bus.state), 0);

    run_op(16'hFFFF, 1'b0, 1'b0, -1, e, b);
    check("full_edges", e, 18);
    check("full_count", 32'(bus.count), 16);
    release_result();

    run_op(16'hFFFF, 1'b1, 1'b0, -1, e, b);
    check("empty_edges", e, 2);
    check("empty_count", 32'(bus.count), 0);
    check("empty_zero", 32'(bus.zero), 1);
    release_result();

    run_op(16'h0F0F, 1'b0, 1'b0, 2, e, b);
    check("stray_count", 32'(bus.count), 8);
    check("stray_edges", e, 10);
    release_result();

    bus.din   = 16'hFFFF;
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_state", 32'(bus.state), 0);
    check("abort_count", 32'(bus.count), 0);
    check("abort_busy", 32'(bus.busy), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) seen++;
    end
    check("abort_no_done", seen, 0);

    run_op(16'h0001, 1'b0, 1'b0, -1, e, b);
    bus.din   = 16'hFFFF;
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_done_state", 32'(bus.state), 0);
    check("abort_done_count", 32'(bus.count), 0);
    check("abort_done_busy", 32'(bus.busy), 0);
    repeat (5) step();
    check("abort_done_stay", 32'(bus.state), 0);

    bus.din   = 16'hAAAA;
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (2) step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_count", 32'(bus.count), 0);
    repeat (2) step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.done) seen++;
    end
    check("arst_no_done", seen, 0);

    b2b = 1'b0;
    for (int i = 0; i < 150; i++) begin
      d = 16'($urandom);
      m = 1'($urandom_range(0, 1));
      k = $countones(m ? ~d : d);
      run_op(d, m, b2b, -1, e, b);
      check("rand_count", 32'(bus.count), k);
      check("rand_edges", e, k + 2);
      repeat ($urandom_range(0, 3)) step();
      b2b = ($urandom_range(0, 3) == 0);
      if (!b2b) release_result();
    end
    if (b2b) release_result();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
